core_mem_responder: RTL and testbench
=====================================

Name: core_mem_responder

Overview:
Shared data-memory responder serving the LD/ST ports of all cores (the memory end of the core enable/addr/wr_data/rd_data/ready_sig interface).
Arbitrates core requests round-robin and serialises them onto one single-port byte memory.
Returns read data and a one-cycle ready_sig per completed access.
Sits between the core array and the global data memory; the address is {core_id_field, offset}, so any core may reach any bank.

Parameters:
CORE_COUNT, 16, number of core ports
REG_SIZE, 8, data width (`REG_SIZE)
CORE_ID_SIZE, 4, upper address field width (`CORE_ID_SIZE)
ADDR_SIZE, 12, address width = CORE_ID_SIZE + REG_SIZE (`ADDR_SIZE)
MEM_LATENCY, 2, cycles from grant to ready pulse; legal range >= 1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  2*CORE_COUNT  per-core request: 01 = LD, 10 = ST, 00/11 = no request; core i uses bits [2i+1:2i]
addr  in  ADDR_SIZE*CORE_COUNT  per-core byte address; stable while request pending
wr_data  in  REG_SIZE*CORE_COUNT  per-core store data
rd_data  out  REG_SIZE*CORE_COUNT  per-core load result, registered
ready_sig  out  CORE_COUNT  per-core completion pulse

Behaviour:
- Reset:
  - ready_sig = 0 and rd_data = 0 for all cores.
  - State goes to IDLE; rr_ptr = 0.
  - Memory contents are not cleared.
- Core contract: the core holds enable/addr/wr_data stable until it sees ready_sig. It captures rd_data at the clock edge ending the ready cycle. In the following cycle it may present a new request, possibly identical to the previous one.
- Valid request mask: req[i] = enable_i is 01 or 10. Code 11 is never granted.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req != 0, grant the first set bit at or after rr_ptr, wrapping modulo CORE_COUNT.
  - Latch the granted index g, the op, and the addr.
  - On the grant edge: for ST, mem[addr_g] <= wr_data_g; for LD, the read word is latched into a data-hold register.
  - Set rr_ptr <= (g+1) mod CORE_COUNT.
  - Next state: WAIT with cnt = MEM_LATENCY-1 if MEM_LATENCY > 1, otherwise RESP.
- WAIT:
  - cnt decrements each cycle; at cnt == 1 go to RESP.
  - Enable changes during WAIT are ignored and the access still completes.
- RESP (exactly one cycle):
  - ready_sig[g] = 1; all other ready_sig bits = 0.
  - For LD, rd_data_g already holds the read word (loaded on entry to RESP). For ST, rd_data_g is unchanged.
  - Next state is always IDLE.
  - Requests seen during RESP are not arbitrated, so the core's stale enable is never double-serviced.
- Latency: request granted in cycle T gives ready_sig in cycle T+MEM_LATENCY. The next grant is no earlier than T+MEM_LATENCY+1.
- rd_data_i holds its last value indefinitely; it changes only on an LD completion for core i.
- Ordering:
  - Accesses are strictly serialised in grant order.
  - A ST granted before an LD to the same address is visible to that LD, whichever cores issue them.
- Fairness: a continuously requesting core waits at most CORE_COUNT-1 other grants.
- ready_sig is registered; it is never combinational from enable.
- Reset mid-operation (WAIT or RESP):
  - Go to IDLE; no ready pulse is issued.
  - A ST already committed on its grant edge remains in memory.
- Addresses are full ADDR_SIZE with no wrap or out-of-range case. Memory depth = 2^ADDR_SIZE.

Decomposition:
- Shared package/header (Inc/Constants.vh) holds:
  - REG_SIZE, CORE_ID_SIZE, ADDR_SIZE, CORE_COUNT.
  - Enable encodings ENABLE_NONE = 2'b00, ENABLE_LD = 2'b01, ENABLE_ST = 2'b10.
  - FSM state encodings.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], ptr.
  - Outputs: grant index, grant_valid.
  - Purely combinational priority rotation, reused later for instruction-broadcast arbitration.
- Memory array is inferred inside core_mem_responder as a single-port register array.

Test Plan:
1. Reset held 3 cycles -> all ready_sig = 0, all rd_data = 0, no grant while reset is high, even with enable_0 = 01.
2. Core 0 ST addr 0x005 data 0xA5 at T, MEM_LATENCY = 2 -> ready_sig[0] = 1 at T+2 only. Then core 0 LD 0x005 -> rd_data_0 = 0xA5 in its ready cycle, held afterwards.
3. Cores 1 and 3 hold LD continuously from reset, rr_ptr = 0 -> grant order 1, 3, 1, 3. Ready pulses are spaced exactly MEM_LATENCY+1 cycles apart; no ready_sig on any other core.
4. Core 2 ST addr 0x1FF data 0x3C, and core 5 LD 0x1FF presented in the same cycle -> core 2 granted first, then core 5 reads 0x3C.
5. Core 4 enable = 11 for 20 cycles -> ready_sig[4] never asserts, memory unchanged, other cores served normally.
6. Core 0 ST 0x010 data 0x77, reset asserted during WAIT -> no ready pulse, IDLE next cycle. A subsequent LD 0x010 returns 0x77.

Source files
------------

// File: rtl/core_mem_responder_pkg.sv
// Shared constants, enable encodings and FSM states for the core data-memory responder.
package core_mem_responder_pkg;

  localparam int REG_SIZE     = 8;
  localparam int CORE_ID_SIZE = 4;
  localparam int ADDR_SIZE    = CORE_ID_SIZE + REG_SIZE;
  localparam int CORE_COUNT   = 16;
  localparam int CORE_IDX_W   = $clog2(CORE_COUNT);

  localparam logic [1:0] ENABLE_NONE = 2'b00;
  localparam logic [1:0] ENABLE_LD   = 2'b01;
  localparam logic [1:0] ENABLE_ST   = 2'b10;

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_WAIT,
    STATE_RESP
  } state_t;

  // Code 11 is deliberately not a request.
  function automatic logic is_request(input logic [1:0] en);
    return (en == ENABLE_LD) || (en == ENABLE_ST);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 16,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         grant_valid
);

  // NOTE: every output and temporary gets a default at the top of always_comb,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    int idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_valid && req[idx]) begin
        grant       = W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_mem_responder.sv
// Shared data-memory responder: round-robin arbitration of per-core LD/ST requests onto
// one single-port byte memory, with registered read data and a one-cycle ready pulse.
module core_mem_responder
  import core_mem_responder_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [2*CORE_COUNT-1:0]        enable,
  input  logic [ADDR_SIZE*CORE_COUNT-1:0] addr,
  input  logic [REG_SIZE*CORE_COUNT-1:0] wr_data,
  output logic [REG_SIZE*CORE_COUNT-1:0] rd_data,
  output logic [CORE_COUNT-1:0]          ready_sig
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [CORE_IDX_W-1:0] rr_ptr;
  logic [CORE_IDX_W-1:0] grant;
  logic [CORE_IDX_W-1:0] gnt_q;
  logic                  grant_valid;
  logic                  op_ld_q;
  logic [REG_SIZE-1:0]   hold;

  logic [CORE_COUNT-1:0] req;
  logic [1:0]            sel_enable;
  logic [ADDR_SIZE-1:0]  sel_addr;
  logic [REG_SIZE-1:0]   sel_wdata;
  logic [REG_SIZE-1:0]   mem_rd;
  logic                  do_store;

  logic [REG_SIZE-1:0]   mem [2**ADDR_SIZE];

  always_comb begin
    req = '0;
    for (int i = 0; i < CORE_COUNT; i++) req[i] = is_request(enable[2*i +: 2]);
  end

  // Arbitration only matters in IDLE, so RESP never re-services a stale enable.
  rr_arbiter #(.N(CORE_COUNT), .W(CORE_IDX_W)) u_arbiter (
    .req        (req),
    .ptr        (rr_ptr),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  always_comb begin
    sel_enable = enable[2*int'(grant) +: 2];
    sel_addr   = addr[ADDR_SIZE*int'(grant) +: ADDR_SIZE];
    sel_wdata  = wr_data[REG_SIZE*int'(grant) +: REG_SIZE];
    mem_rd     = mem[sel_addr];
    do_store   = !reset && (state == STATE_IDLE) && grant_valid && (sel_enable == ENABLE_ST);
  end

  // NOTE: the memory array is intentionally left out of reset so its contents survive
  // a reset and it can map onto a plain RAM; only control state is reset.
  always_ff @(posedge clk) begin
    if (do_store) mem[sel_addr] <= sel_wdata;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= STATE_IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      gnt_q     <= '0;
      op_ld_q   <= 1'b0;
      hold      <= '0;
      ready_sig <= '0;
      rd_data   <= '0;
    end else begin
      ready_sig <= '0;
      unique case (state)
        STATE_IDLE: begin
          if (grant_valid) begin
            gnt_q   <= grant;
            op_ld_q <= (sel_enable == ENABLE_LD);
            hold    <= mem_rd;
            rr_ptr  <= (grant == CORE_IDX_W'(CORE_COUNT-1)) ? '0 : grant + CORE_IDX_W'(1);
            if (MEM_LATENCY > 1) begin
              state <= STATE_WAIT;
              cnt   <= CNT_W'(MEM_LATENCY-1);
            end else begin
              state            <= STATE_RESP;
              ready_sig[grant] <= 1'b1;
              if (sel_enable == ENABLE_LD) rd_data[REG_SIZE*int'(grant) +: REG_SIZE] <= mem_rd;
            end
          end
        end
        STATE_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state            <= STATE_RESP;
            ready_sig[gnt_q] <= 1'b1;
            if (op_ld_q) rd_data[REG_SIZE*int'(gnt_q) +: REG_SIZE] <= hold;
          end
        end
        STATE_RESP: state <= STATE_IDLE;
        default:    state <= STATE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench: batches of core requests are predicted by a round-robin service model.
module tb_core_mem_responder;
  import core_mem_responder_pkg::*;

  localparam int L  = 2;
  localparam int NC = CORE_COUNT;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [2*NC-1:0]           enable;
  logic [ADDR_SIZE*NC-1:0]   addr;
  logic [REG_SIZE*NC-1:0]    wr_data;
  logic [REG_SIZE*NC-1:0]    rd_data;
  logic [NC-1:0]             ready_sig;

  core_mem_responder #(.MEM_LATENCY(L)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .ready_sig(ready_sig)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         core;
    bit         is_ld;
    logic [7:0] data;
    int         cycle;
  } exp_t;

  exp_t                 sb[$];
  int                   checks = 0;
  int                   errors = 0;
  int                   cyc = 0;
  logic [7:0]           model_mem [int];
  logic [7:0]           model_rd [NC];
  int                   model_ptr = 0;

  logic [1:0]           b_en  [NC];
  logic [ADDR_SIZE-1:0] b_ad  [NC];
  logic [7:0]           b_wd  [NC];
  int                   b_rep [NC];
  logic [ADDR_SIZE-1:0] pool  [16];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [REG_SIZE*NC-1:0] pack_rd();
    logic [REG_SIZE*NC-1:0] v;
    v = '0;
    for (int i = 0; i < NC; i++) v[i*REG_SIZE +: REG_SIZE] = model_rd[i];
    return v;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every ready pulse must match the head of the scoreboard.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (ready_sig !== '0) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 128'(ready_sig), '0);
      end else begin
        e = sb.pop_front();
        check("ready_core", 128'(ready_sig), 128'(1) << e.core);
        check("ready_cycle", 128'(cyc), 128'(e.cycle));
        if (e.is_ld) model_rd[e.core] = e.data;
        check("rd_data", rd_data, pack_rd());
      end
    end
  end

  task automatic clear_batch();
    for (int i = 0; i < NC; i++) begin
      b_en[i] = 2'b00; b_ad[i] = '0; b_wd[i] = '0; b_rep[i] = 1;
    end
  endtask

  // Present b_* at once, predict the full service order, then drive until every core is served.
  task automatic run_batch();
    int rem [NC];
    int c, n, budget;
    bit busy;
    exp_t e;
    for (int i = 0; i < NC; i++) begin
      enable[2*i +: 2]                = b_en[i];
      addr[ADDR_SIZE*i +: ADDR_SIZE]  = b_ad[i];
      wr_data[REG_SIZE*i +: REG_SIZE] = b_wd[i];
      rem[i] = (b_en[i] == 2'b01 || b_en[i] == 2'b10) ? b_rep[i] : 0;
    end
    n = 0;
    while (1) begin
      c = -1;
      for (int k = 0; k < NC; k++) begin
        int j;
        j = (model_ptr + k) % NC;
        if (c < 0 && rem[j] > 0) c = j;
      end
      if (c < 0) break;
      e.core  = c;
      e.is_ld = (b_en[c] == 2'b01);
      e.cycle = cyc + L + n * (L + 1);
      e.data  = '0;
      if (e.is_ld) e.data = model_mem[int'(b_ad[c])];
      else         model_mem[int'(b_ad[c])] = b_wd[c];
      sb.push_back(e);
      rem[c]--;
      model_ptr = (c + 1) % NC;
      n++;
    end
    for (int i = 0; i < NC; i++) rem[i] = (b_en[i] == 2'b01 || b_en[i] == 2'b10) ? b_rep[i] : 0;
    budget = n * (L + 1) + 8;
    busy = (n > 0);
    while (busy && budget > 0) begin
      @(negedge clk);
      budget--;
      busy = 1'b0;
      for (int i = 0; i < NC; i++) begin
        if (ready_sig[i] && rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) enable[2*i +: 2] = 2'b00;
        end
        if (rem[i] > 0) busy = 1'b1;
      end
    end
    check("batch_done", 128'(busy), '0);
    enable = '0;
    @(negedge clk);
    check("scoreboard_drained", 128'(sb.size()), '0);
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset   = 1'b1;
    enable  = '0;
    addr    = '0;
    wr_data = '0;
    enable[1:0] = ENABLE_LD;
    for (int i = 0; i < NC; i++) model_rd[i] = '0;
    for (int i = 0; i < 16; i++) pool[i] = ADDR_SIZE'($urandom_range(0, 4095));

    // Reset held three cycles with a pending LD on core 0.
    repeat (3) begin
      @(negedge clk);
      check("reset_ready", 128'(ready_sig), '0);
      check("reset_rd_data", rd_data, '0);
    end
    reset  = 1'b0;
    enable = '0;
    @(negedge clk);

    // Core 0 store then load of 0x005.
    clear_batch(); b_en[0] = ENABLE_ST; b_ad[0] = 12'h005; b_wd[0] = 8'hA5; run_batch();
    clear_batch(); b_en[0] = ENABLE_LD; b_ad[0] = 12'h005; run_batch();
    repeat (3) @(negedge clk);
    check("rd_hold_core0", 128'(rd_data[7:0]), 128'(8'hA5));

    // Same-cycle ST by core 2 and LD by core 5 to 0x1FF.
    clear_batch();
    b_en[2] = ENABLE_ST; b_ad[2] = 12'h1FF; b_wd[2] = 8'h3C;
    b_en[5] = ENABLE_LD; b_ad[5] = 12'h1FF;
    run_batch();
    check("st_before_ld", 128'(rd_data[5*REG_SIZE +: REG_SIZE]), 128'(8'h3C));

    // Cores 1 and 3 request continuously: two services each, back to back.
    clear_batch();
    b_en[1] = ENABLE_LD; b_ad[1] = 12'h005; b_rep[1] = 2;
    b_en[3] = ENABLE_LD; b_ad[3] = 12'h1FF; b_rep[3] = 2;
    run_batch();

    // Core 4 presents code 11 with store data while others are served, then alone.
    clear_batch();
    b_en[4] = 2'b11;     b_ad[4] = 12'h005; b_wd[4] = 8'hFF;
    b_en[0] = ENABLE_LD; b_ad[0] = 12'h005;
    b_en[7] = ENABLE_ST; b_ad[7] = 12'h222; b_wd[7] = 8'h5A;
    b_en[9] = ENABLE_LD; b_ad[9] = 12'h1FF;
    run_batch();
    enable[9:8] = 2'b11; addr[4*ADDR_SIZE +: ADDR_SIZE] = 12'h005; wr_data[4*REG_SIZE +: REG_SIZE] = 8'hFF;
    repeat (12) @(negedge clk);
    enable = '0;
    @(negedge clk);
    clear_batch(); b_en[4] = ENABLE_LD; b_ad[4] = 12'h005; run_batch();

    // Reset during WAIT: the store stays committed, no ready pulse.
    enable[1:0] = ENABLE_ST; addr[11:0] = 12'h010; wr_data[7:0] = 8'h77;
    @(negedge clk);
    reset  = 1'b1;
    enable = '0;
    model_mem[12'h010] = 8'h77;
    model_ptr = 0;
    for (int i = 0; i < NC; i++) model_rd[i] = '0;
    @(negedge clk);
    check("midreset_ready", 128'(ready_sig), '0);
    check("midreset_rd_data", rd_data, '0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 128'(ready_sig), '0);
    clear_batch(); b_en[0] = ENABLE_LD; b_ad[0] = 12'h010; run_batch();

    // Randomized batches drawn from a small address pool to force collisions.
    for (int t = 0; t < 40; t++) begin
      clear_batch();
      for (int i = 0; i < NC; i++) begin
        r = $urandom_range(0, 9);
        b_ad[i]  = pool[$urandom_range(0, 15)];
        b_wd[i]  = 8'($urandom);
        b_rep[i] = ($urandom_range(0, 3) == 0) ? 2 : 1;
        if (r == 4 || r == 5) b_en[i] = model_mem.exists(int'(b_ad[i])) ? ENABLE_LD : ENABLE_ST;
        else if (r == 6 || r == 7) b_en[i] = ENABLE_ST;
        else if (r == 8) b_en[i] = 2'b11;
        else b_en[i] = ENABLE_NONE;
      end
      run_batch();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
